// File: rtl/a_fall_monitor.sv
// ============================================================================
// Module   : a_fall_monitor
// Brief    : Synchronizes level A, rejects short low glitches and reports
//            qualified falls (pulse, saturating counters, sticky irq).
//            Optional macro A_FALL_TIMESTAMP_EN adds a cycle-stamped last fall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module a_fall_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_in,
  input  logic             clr,
  input  logic             irq_ack,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             irq,
`ifdef A_FALL_TIMESTAMP_EN
  output logic [31:0]      last_fall_ts,
`endif
  output logic             a_sync
);

  localparam int         c_QW      = $clog2(MIN_LOW + 1);
  localparam [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    QUAL = 2'd2,
    LOW  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_QW-1:0]        r_qcnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_fall_pulse;
  logic [CNT_W-1:0]       r_fall_cnt;
  logic [CNT_W-1:0]       r_glitch_cnt;
  logic                   r_irq;
  logic                   w_a_sync;
  logic                   w_qualify;
  logic                   w_glitch;

  assign w_a_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a_in};
    end
  end

  // Qualify/glitch events are decoded from the current state so the pulse,
  // counters and irq all update on the same edge as the state transition.
  always_comb begin
    w_qualify = 1'b0;
    w_glitch  = 1'b0;
    if (en) begin
      case (r_state)
        HIGH: w_qualify = !w_a_sync && (MIN_LOW == 1);
        QUAL: begin
          w_qualify = !w_a_sync && (r_qcnt == c_QW'(MIN_LOW - 1));
          w_glitch  = w_a_sync;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARM;
      r_qcnt       <= '0;
      r_fall_pulse <= 1'b0;
      r_fall_cnt   <= '0;
      r_glitch_cnt <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_fall_pulse <= w_qualify;

      if (!en) begin
        r_state <= ARM;
        r_qcnt  <= '0;
      end else begin
        case (r_state)
          ARM: if (w_a_sync) r_state <= HIGH;
          HIGH: begin
            if (!w_a_sync) begin
              if (MIN_LOW == 1) begin
                r_state <= LOW;
              end else begin
                r_state <= QUAL;
                r_qcnt  <= c_QW'(1);
              end
            end
          end
          QUAL: begin
            if (w_a_sync) begin
              r_state <= HIGH;
              r_qcnt  <= '0;
            end else if (w_qualify) begin
              r_state <= LOW;
              r_qcnt  <= '0;
            end else begin
              r_qcnt <= r_qcnt + c_QW'(1);
            end
          end
          LOW: if (w_a_sync) r_state <= HIGH;
          default: r_state <= ARM;
        endcase
      end

      // clr dominates any coincident event; a fresh qualify dominates irq_ack.
      if (clr) begin
        r_fall_cnt   <= '0;
        r_glitch_cnt <= '0;
        r_irq        <= 1'b0;
      end else begin
        if (w_qualify && (r_fall_cnt != c_CNT_MAX)) r_fall_cnt <= r_fall_cnt + 1'b1;
        if (w_glitch && (r_glitch_cnt != c_CNT_MAX)) r_glitch_cnt <= r_glitch_cnt + 1'b1;
        if (w_qualify) begin
          r_irq <= 1'b1;
        end else if (irq_ack) begin
          r_irq <= 1'b0;
        end
      end
    end
  end

`ifdef A_FALL_TIMESTAMP_EN
  logic [31:0] r_cyc;
  logic [31:0] r_last_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc     <= '0;
      r_last_ts <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_qualify) r_last_ts <= r_cyc;
    end
  end

  assign last_fall_ts = r_last_ts;
`endif

  assign fall_pulse = r_fall_pulse;
  assign fall_cnt   = r_fall_cnt;
  assign glitch_cnt = r_glitch_cnt;
  assign irq        = r_irq;
  assign a_sync     = w_a_sync;

endmodule

`default_nettype wire
